// File: rtl/conditional_sum_adder_pipe.sv
// conditional_sum_adder_pipe
//   Two-stage pipelined conditional-sum adder/subtractor with valid/ready
//   handshakes on both sides.
//
//   Stage 1 splits the operands into WIDTH/BLOCK groups. For each group it
//   registers both candidate results: the group sum and carry assuming a
//   group carry-in of 0, and assuming a group carry-in of 1. It also
//   registers the effective carry-in.
//   Stage 2 resolves the real group carries with a 2:1 mux chain, picks the
//   matching sums, and registers sum, cout and ovf.
//
// Parameters
//   WIDTH     operand width, 4..64, a multiple of BLOCK
//   BLOCK     conditional-sum group width, 2..WIDTH
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   in_valid  operands and mode present
//   in_ready  block accepts operands this cycle
//   A, B      operands (unsigned or two's complement)
//   cin       carry-in; used in add mode only
//   sub       0: A+B+cin, 1: A-B computed as A+~B+1
//   out_valid result registers hold an unconsumed result
//   out_ready downstream consumes the result
//   sum       WIDTH-bit result
//   cout      carry out of the MSB; in sub mode 1 means no borrow
//   ovf       signed overflow
module conditional_sum_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / BLOCK;

  // One group adder: (BLOCK+1)-bit result {carry, sum}.
  function automatic logic [BLOCK:0] grp_add(input logic [BLOCK-1:0] a,
                                             input logic [BLOCK-1:0] b,
                                             input logic             c);
    return {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, c};
  endfunction

  logic                     vld_p1, vld_p2;
  logic                     en_p1, en_p2;
  logic [WIDTH-1:0]         b_eff;
  logic                     c_eff;
  logic [NG-1:0][BLOCK-1:0] gsum0_d, gsum1_d, gsum0_p1, gsum1_p1;
  logic [NG-1:0]            gcy0_d, gcy1_d, gcy0_p1, gcy1_p1;
  logic                     cin_p1, msbx_p1;
  logic [WIDTH-1:0]         sum_d, sum_p2;
  logic                     cout_d, ovf_d, cout_p2, ovf_p2;

  // A stage loads when it is empty or its contents move on this cycle.
  assign en_p2     = ~vld_p2 | out_ready;
  assign en_p1     = ~vld_p1 | en_p2;
  assign in_ready  = ~rst & en_p1;
  assign out_valid = vld_p2;
  assign sum       = sum_p2;
  assign cout      = cout_p2;
  assign ovf       = ovf_p2;

  // Subtraction is A + ~B + 1; cin only matters in add mode.
  assign b_eff = sub ? ~B : B;
  assign c_eff = sub | cin;

  always_comb begin
    gsum0_d = '0;
    gsum1_d = '0;
    gcy0_d  = '0;
    gcy1_d  = '0;
    for (int g = 0; g < NG; g++) begin
      {gcy0_d[g], gsum0_d[g]} = grp_add(A[g*BLOCK +: BLOCK], b_eff[g*BLOCK +: BLOCK], 1'b0);
      {gcy1_d[g], gsum1_d[g]} = grp_add(A[g*BLOCK +: BLOCK], b_eff[g*BLOCK +: BLOCK], 1'b1);
    end
  end

  // ---- stage 1: conditional group results ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (en_p1) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en_p1 && in_valid) begin
      gsum0_p1 <= gsum0_d;
      gsum1_p1 <= gsum1_d;
      gcy0_p1  <= gcy0_d;
      gcy1_p1  <= gcy1_d;
      cin_p1   <= c_eff;
      // Operand MSB parity lets stage 2 recover the carry into the MSB.
      msbx_p1  <= A[WIDTH-1] ^ b_eff[WIDTH-1];
    end
  end

  // Carry select chain: each group's real carry-in picks its candidate.
  always_comb begin
    logic carry;
    carry = cin_p1;
    sum_d = '0;
    for (int g = 0; g < NG; g++) begin
      sum_d[g*BLOCK +: BLOCK] = carry ? gsum1_p1[g] : gsum0_p1[g];
      carry                   = carry ? gcy1_p1[g]  : gcy0_p1[g];
    end
    cout_d = carry;
    // carry into MSB = sum_msb ^ a_msb ^ b_msb; overflow = that ^ cout
    ovf_d  = carry ^ sum_d[WIDTH-1] ^ msbx_p1;
  end

  // ---- stage 2: resolved result registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      sum_p2  <= '0;
      cout_p2 <= 1'b0;
      ovf_p2  <= 1'b0;
    end else if (en_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        sum_p2  <= sum_d;
        cout_p2 <= cout_d;
        ovf_p2  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_conditional_sum_adder_pipe.sv
// Testbench for conditional_sum_adder_pipe: directed table at WIDTH=16,
// handshake/stall/reset sequences, and exhaustive sweeps on 8/2 and 4/4
// instances.
module tb_conditional_sum_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic [15:0] sum;
  logic        cout, ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conditional_sum_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // Reference: {ovf, cout, sum zero-extended to 64 bits}.
  function automatic logic [65:0] model(input int w, input logic [63:0] av,
                                        input logic [63:0] bv, input logic ci,
                                        input logic sb);
    logic [63:0] mask, be, mlow;
    logic [64:0] full, low, t;
    logic        c, co, cm;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    mlow = mask >> 1;
    be   = sb ? (~bv & mask) : (bv & mask);
    c    = sb ? 1'b1 : ci;
    full = {1'b0, av & mask} + {1'b0, be} + {64'd0, c};
    t    = full >> w;
    co   = t[0];
    low  = {1'b0, av & mlow} + {1'b0, be & mlow} + {64'd0, c};
    t    = low >> (w - 1);
    cm   = t[0];
    return {co ^ cm, co, full[63:0] & mask};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- exhaustive instances ----------------
  logic        xv, yv;
  logic [13:0] x, x2;   // 8-bit sweep index: {A[5:0], B[7:0]}
  logic [9:0]  y, y2;   // 4-bit sweep index: {sub, cin, B, A}
  logic [15:0] mis8;
  logic        mis4;

  for (genvar gi = 0; gi < 16; gi++) begin : g_ex8
    localparam logic [3:0] ID = 4'(gi);
    logic [7:0]  ai, s;
    logic        co, ov, ovld, ird;
    logic [65:0] e;
    assign ai = {ID[3:2], x[13:8]};
    conditional_sum_adder_pipe #(.WIDTH(8), .BLOCK(2)) u (
      .clk(clk), .rst(rst), .in_valid(xv), .in_ready(ird),
      .A(ai), .B(x[7:0]), .cin(ID[0]), .sub(ID[1]),
      .out_valid(ovld), .out_ready(1'b1),
      .sum(s), .cout(co), .ovf(ov)
    );
    assign e = model(8, {56'd0, ID[3:2], x2[13:8]}, {56'd0, x2[7:0]}, ID[0], ID[1]);
    assign mis8[gi] = !ovld || !ird || ({ov, co, 56'd0, s} != e);
  end

  logic [3:0]  s4;
  logic        co4, ov4, ovld4, ird4;
  logic [65:0] e4;
  conditional_sum_adder_pipe #(.WIDTH(4), .BLOCK(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(yv), .in_ready(ird4),
    .A(y[3:0]), .B(y[7:4]), .cin(y[8]), .sub(y[9]),
    .out_valid(ovld4), .out_ready(1'b1),
    .sum(s4), .cout(co4), .ovf(ov4)
  );
  assign e4   = model(4, {60'd0, y2[3:0]}, {60'd0, y2[7:4]}, y2[8], y2[9]);
  assign mis4 = !ovld4 || !ird4 || ({ov4, co4, 60'd0, s4} != e4);

  // ---------------- directed table ----------------
  typedef struct {
    logic [15:0] a, b;
    logic        ci, sb;
    logic [15:0] es;
    logic        ec, eo;
  } vec_t;

  vec_t        tbl[14];
  logic [17:0] expq[$];
  logic [17:0] exp_r;
  logic [65:0] m;

  task automatic push_model();
    m = model(16, {48'd0, a}, {48'd0, b}, cin, sub);
    expq.push_back({m[65], m[64], m[15:0]});
  endtask

  // Pops one expected result when out_valid is seen at the current sample.
  task automatic collect(input string name, inout int got);
    if (out_valid) begin
      got++;
      if (expq.size() == 0) begin
        chk({name, "_extra"}, 64'(1), 64'(0));
      end else begin
        exp_r = expq.pop_front();
        chk(name, 64'({ovf, cout, sum}), 64'(exp_r));
      end
    end
  endtask

  initial begin
    int got, first_c, last_c, acc, stale;
    logic [17:0] held;

    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[7]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[8]  = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[10] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[11] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[12] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tbl[13] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    xv = 1'b0; yv = 1'b0; x = '0; x2 = '0; y = '0; y2 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_outputs", 64'({ovf, cout, sum}), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Directed table, one transfer at a time, checking the 2-cycle latency
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      a = tbl[i].a; b = tbl[i].b; cin = tbl[i].ci; sub = tbl[i].sb;
      in_valid = 1'b1;
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(1));
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_lat1", i), 64'(out_valid), 64'(0));
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(1));
      chk($sformatf("tbl%0d_result", i), 64'({ovf, cout, sum}),
          64'({tbl[i].eo, tbl[i].ec, tbl[i].es}));
    end

    // Back-to-back stream of 8 random operand sets
    @(negedge clk);
    got = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      collect("stream", got);
      if (c < 8) begin
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        in_valid = 1'b1;
        chk("stream_in_ready", 64'(in_ready), 64'(1));
        push_model();
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("stream_count", 64'(got), 64'(8));
    chk("stream_consecutive", 64'(last_c - first_c), 64'(7));
    chk("stream_first_latency", 64'(first_c), 64'(2));

    // Stall: out_ready low for 5 cycles with in_valid high
    @(negedge clk);
    out_ready = 1'b0;
    acc = 0; held = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a = 16'h1111 * 16'(c + 1); b = 16'h0F0F; cin = 1'b1; sub = 1'(c);
      in_valid = 1'b1;
      if (in_ready) begin
        acc++;
        push_model();
      end
      if (c == 2) held = {ovf, cout, sum};
      if (c == 4) begin
        chk("stall_in_ready_low", 64'(in_ready), 64'(0));
        chk("stall_out_valid", 64'(out_valid), 64'(1));
        chk("stall_hold", 64'({ovf, cout, sum}), 64'(held));
      end
    end
    chk("stall_accepted", 64'(acc), 64'(2));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      collect("stall_drain", got);
      @(negedge clk);
    end
    chk("stall_drain_count", 64'(got), 64'(2));

    // Reset with two results in flight
    a = 16'h0102; b = 16'h0304; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'hA0A0; b = 16'h0505;
    @(negedge clk);
    in_valid = 1'b0;
    chk("inflight_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_outputs", 64'({ovf, cout, sum}), 64'(0));
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("rst_no_stale", 64'(stale), 64'(0));

    // Exhaustive: 16 instances of 8/2 (one per A[7:6] x {sub,cin}) and one 4/4
    for (int k = 0; k < 16384 + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if (mis8 != 16'd0) begin
          errors++;
          $display("FAIL ex8 idx=%0h lanes=%04h: got mismatching lanes, required 0000",
                   x2, mis8);
        end
      end
      if (k >= 2 && k - 2 < 1024) begin
        checks++;
        if (mis4) begin
          errors++;
          $display("FAIL ex4 idx=%0h: got {ovf,cout,sum}=%0h%0h%0h valid=%0b, required %0h%0h%0h",
                   y2, ov4, co4, s4, ovld4, e4[65], e4[64], e4[3:0]);
        end
      end
      x2 = x;
      y2 = y;
      if (k < 16384) begin
        xv = 1'b1; x = 14'(k);
      end else begin
        xv = 1'b0;
      end
      if (k < 1024) begin
        yv = 1'b1; y = 10'(k);
      end else begin
        yv = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conditional_sum_adder_pipe.md
CONDITIONAL_SUM_ADDER_PIPE -- requirements
Module: conditional_sum_adder_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits (legal: 4..64, multiple of BLOCK).
REQ-002 The block SHALL have parameter BLOCK, default 4, conditional-sum group width in bits (legal: 2..WIDTH).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  operands and mode present.
REQ-006 The block SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 The block SHALL have ports A and B  input  WIDTH  unsigned or two's-complement operands.
REQ-008 The block SHALL have port cin  input  1  carry-in, used in add mode only.
REQ-009 The block SHALL have port sub  input  1  0 = A+B+cin; 1 = A-B, computed as A+~B+1 with cin ignored.
REQ-010 The block SHALL have port out_valid  output  1  result registers hold an unconsumed result.
REQ-011 The block SHALL have port out_ready  input  1  downstream consumes the result.
REQ-012 The block SHALL have port sum  output  WIDTH  result bits [WIDTH-1:0].
REQ-013 The block SHALL have port cout  output  1  carry out of bit WIDTH-1; in sub mode, 1 = no borrow.
REQ-014 The block SHALL have port ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 Stage 1 SHALL register, per BLOCK group, both conditional results: {carry, sum} for group carry-in 0 and for group carry-in 1, plus the effective carry-in.
REQ-016 Stage 2 SHALL resolve the group carries with a 2:1 mux chain driven by the stage-1 conditional carries, and register sum, cout and ovf.
REQ-017 Latency SHALL be exactly 2 cycles from an accepted transfer to out_valid=1 when out_ready stays 1.
REQ-018 An input transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge; an output transfer SHALL occur when out_valid and out_ready are both 1 on a rising edge.
REQ-019 Each stage SHALL carry a valid bit; a stage SHALL load when it is empty or its contents move forward in the same cycle.
REQ-020 in_ready SHALL equal NOT stage1_valid OR (NOT stage2_valid OR out_ready), a combinational function of registered state and out_ready only, with no dependence on in_valid.
REQ-021 With out_ready held at 1, the block SHALL accept one operand set per cycle (full throughput, 2 in flight).
REQ-022 With out_ready=0 and both stages valid, in_ready SHALL be 0, and sum/cout/ovf SHALL hold stable until the output transfer.
REQ-023 An output transfer and an input transfer in the same cycle SHALL both occur, with no bubble or loss.
REQ-024 Results SHALL leave in acceptance order; no transfer SHALL be dropped or duplicated.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH on sum, with cout equal to bit WIDTH of the (WIDTH+1)-bit true result.
REQ-026 When WIDTH equals BLOCK, the block SHALL degenerate to a single group, and behaviour SHALL remain per REQ-015..025.

Reset
REQ-027 While rst=1 on a rising edge, both stage valid bits, out_valid, sum, cout and ovf SHALL be cleared to 0.
REQ-028 During the cycle rst is 1, in_ready SHALL be 0; in the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight results, and no out_valid SHALL follow from pre-reset inputs.

Verification
REQ-030 Scenario, default params: A=16'hFFFF, B=16'h0001, cin=0, sub=0, out_ready=1 -> 2 cycles later sum=16'h0000, cout=1, ovf=0.
REQ-031 Scenario: A=16'h7FFF, B=16'h0001, add -> sum=16'h8000, cout=0, ovf=1; A=16'h0005, B=16'h0007, sub=1, cin=1 -> sum=16'hFFFE, cout=0, ovf=0 (cin ignored).
REQ-032 Scenario: back-to-back stream of 8 random operand sets with out_ready=1 -> in_ready is constantly 1 and 8 results arrive in consecutive cycles, in order, matching the model.
REQ-033 Scenario: out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 transfers are accepted, in_ready falls to 0, and the outputs hold; out_ready=1 releases results in order with no loss.
REQ-034 Scenario: rst pulsed with 2 results in flight -> out_valid=0 and outputs are 0 next cycle, and no stale result appears.
REQ-035 Scenario: exhaustive test at WIDTH=8, BLOCK=2 and at WIDTH=BLOCK=4 over all A, B, cin and sub -> every result matches the reference model.
